// File: rtl/seqdet_param.sv
// Runtime-loadable serial sequence detector with overlap/non-overlap modes.
// Optional saturating match counter is compiled in with SEQDET_COUNT_EN.
module seqdet_param #(
    parameter int unsigned      PAT_W   = 8,
    parameter int unsigned      LEN_W   = 4,
    parameter int unsigned      CNT_W   = 16,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'h12),
    parameter int unsigned      DEF_LEN = 5,
    parameter bit               DEF_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             ovl_in,
    output logic             z,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             z_q, z_d;
    logic             armed_q, armed_d;

    logic [PAT_W-1:0] hist_sh;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_inc;
    logic [LEN_W-1:0] fill_sh;
    logic             hit;

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        z_d     = 1'b0;

        hist_sh  = {hist_q[PAT_W-2:0], x};
        fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
        fill_sh  = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];

        // Only the low len bits of history take part in the compare.
        mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit = (len_q != '0) && (fill_sh == len_q) && (((hist_sh ^ pat_q) & mask) == '0);

        if (pat_load) begin
            pat_d  = pat_in;
            len_d  = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
            ovl_d  = ovl_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_sh;
            fill_d = fill_sh;
            if (hit) begin
                z_d = 1'b1;
                if (!ovl_q) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end

        armed_d = (len_d != '0) && (fill_d >= len_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= DEF_PAT;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= DEF_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            armed_q <= armed_d;
        end
    end

    assign z     = z_q;
    assign armed = armed_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts on the same edge that raises z, holding at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (z_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
